// File: rtl/mdu_pkg.sv
// Shared types and constants for the multi-cycle multiply/divide unit.
// Request codes, the state encoding and the iteration bound live here.
package mdu_pkg;

  localparam int unsigned W_FUNC = 5;

  localparam logic [W_FUNC-1:0] FUNC_NONE = 5'b00000;
  localparam logic [W_FUNC-1:0] FUNC_MUL  = 5'b00001;
  localparam logic [W_FUNC-1:0] FUNC_DIV  = 5'b00010;

  typedef enum logic [1:0] {
    StIdle,
    StMul,
    StDiv,
    StDone
  } mdu_state_e;

  localparam logic [5:0]  ITER_LAST = 6'd31;
  localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;

  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

  function automatic logic [31:0] neg32(input logic [31:0] v, input logic en);
    return en ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/div_restoring.sv
// Iterative unsigned restoring divider: one quotient bit per step, MSB first.
// The dividend shifts out of quot while quotient bits shift in from the bottom.
module div_restoring (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        load,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  input  logic        step,
  output logic [31:0] rem,
  output logic [31:0] quot
);

  logic [31:0] rem_q, quot_q, dvs_q;
  logic [32:0] trial;
  logic [31:0] diff;
  logic        ge;

  always_comb begin
    trial = {rem_q, quot_q[31]};
    ge    = trial >= {1'b0, dvs_q};
    // When ge holds the true difference is below the divisor, so 32 bits suffice.
    diff  = trial[31:0] - dvs_q;
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      rem_q  <= 32'd0;
      quot_q <= 32'd0;
      dvs_q  <= 32'd0;
    end else if (load) begin
      rem_q  <= 32'd0;
      quot_q <= dividend;
      dvs_q  <= divisor;
    end else if (step) begin
      rem_q  <= ge ? diff : trial[31:0];
      quot_q <= {quot_q[30:0], ge};
    end
  end

  assign rem  = rem_q;
  assign quot = quot_q;

endmodule

// File: rtl/mulalu.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit; holds the pipeline via stall and
// pulses done together with the HI/LO write strobes when the result is ready.
module mulalu
  import mdu_pkg::*;
#(
  parameter int unsigned FAST_MUL = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [W_FUNC-1:0] func,
  input  logic              sign,
  input  logic [31:0]       source_a,
  input  logic [31:0]       source_b,
  input  logic              flush,
  output logic              stall,
  output logic              done,
  output logic              hi_write,
  output logic [31:0]       hi_write_data,
  output logic              lo_write,
  output logic [31:0]       lo_write_data
);

  mdu_state_e  state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] mcand_q, raw_a_q;
  logic [63:0] acc_q;
  logic        neg_q_q, neg_r_q, div0_q, is_div_q;

  logic        req_valid, accept, mul_step, div_step;
  logic [31:0] mag_a, mag_b;
  logic [32:0] add_sum;
  logic [63:0] fast_prod, mul_res;
  logic [31:0] div_rem, div_quot;

  // Unknown nonzero codes are treated exactly like "no request".
  assign req_valid = (func == FUNC_MUL) || (func == FUNC_DIV);
  assign accept    = (state_q == StIdle) && req_valid && !flush;
  assign mul_step  = (state_q == StMul) && !flush;
  assign div_step  = (state_q == StDiv) && !flush;

  assign mag_a = sign ? abs32(source_a) : source_a;
  assign mag_b = sign ? abs32(source_b) : source_b;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = (func == FUNC_DIV) ? StDiv : StMul;
          cnt_d   = 6'd0;
        end
      end
      StMul: begin
        if (FAST_MUL != 0 || cnt_q == ITER_LAST) begin
          state_d = StDone;
          cnt_d   = 6'd0;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      StDiv: begin
        if (cnt_q == ITER_LAST) begin
          state_d = StDone;
          cnt_d   = 6'd0;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (flush) begin
      state_d = StIdle;
      cnt_d   = 6'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 6'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Shift-add: add the multiplicand into the upper half when the low bit is set, then shift right.
  assign add_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, mcand_q} : 33'd0);
  assign fast_prod = {32'd0, mcand_q} * {32'd0, acc_q[31:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q  <= 32'd0;
      raw_a_q  <= 32'd0;
      acc_q    <= 64'd0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      div0_q   <= 1'b0;
      is_div_q <= 1'b0;
    end else if (accept) begin
      mcand_q  <= mag_a;
      raw_a_q  <= source_a;
      acc_q    <= {32'd0, mag_b};
      neg_q_q  <= sign & (source_a[31] ^ source_b[31]);
      neg_r_q  <= sign & source_a[31];
      div0_q   <= (source_b == 32'd0);
      is_div_q <= (func == FUNC_DIV);
    end else if (mul_step) begin
      if (FAST_MUL != 0) begin
        acc_q <= fast_prod;
      end else begin
        acc_q <= {add_sum, acc_q[31:1]};
      end
    end
  end

  div_restoring u_div (
    .clk      (clk),
    .rst      (rst),
    .clear    (flush),
    .load     (accept),
    .dividend (mag_a),
    .divisor  (mag_b),
    .step     (div_step),
    .rem      (div_rem),
    .quot     (div_quot)
  );

  assign mul_res = neg_q_q ? (~acc_q + 64'd1) : acc_q;

  always_comb begin
    stall         = 1'b0;
    done          = 1'b0;
    hi_write_data = 32'd0;
    lo_write_data = 32'd0;
    if (!rst && !flush) begin
      stall = accept || (state_q == StMul) || (state_q == StDiv);
      done  = (state_q == StDone);
    end
    if (done) begin
      if (!is_div_q) begin
        hi_write_data = mul_res[63:32];
        lo_write_data = mul_res[31:0];
      end else if (div0_q) begin
        hi_write_data = raw_a_q;
        lo_write_data = DIV0_QUOT;
      end else begin
        hi_write_data = neg32(div_rem, neg_r_q);
        lo_write_data = neg32(div_quot, neg_q_q);
      end
    end
  end

  assign hi_write = done;
  assign lo_write = done;

endmodule

// File: tb/tb_mulalu.sv
// Directed bench for mulalu: latency, results, flush and reset behaviour,
// with a second instance built for single-cycle multiply.
module tb_mulalu;
  import mdu_pkg::*;

  logic        clk, rst, sign, flush;
  logic [4:0]  func;
  logic [31:0] source_a, source_b;
  logic        stall, done, hi_write, lo_write;
  logic [31:0] hi_write_data, lo_write_data;
  logic        f_stall, f_done, f_hi_write, f_lo_write;
  logic [31:0] f_hi_write_data, f_lo_write_data;

  int errors = 0;
  int checks = 0;

  mulalu #(.FAST_MUL(0)) dut (
    .clk(clk), .rst(rst), .func(func), .sign(sign), .source_a(source_a), .source_b(source_b),
    .flush(flush), .stall(stall), .done(done), .hi_write(hi_write),
    .hi_write_data(hi_write_data), .lo_write(lo_write), .lo_write_data(lo_write_data)
  );

  mulalu #(.FAST_MUL(1)) dut_fast (
    .clk(clk), .rst(rst), .func(func), .sign(sign), .source_a(source_a), .source_b(source_b),
    .flush(flush), .stall(f_stall), .done(f_done), .hi_write(f_hi_write),
    .hi_write_data(f_hi_write_data), .lo_write(f_lo_write), .lo_write_data(f_lo_write_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Issues one request in the current (idle) cycle and follows it to its done pulse.
  // lat counts cycles after the accept cycle; -1 means no done within the budget.
  task automatic run_op(input logic [4:0] f, input logic s, input logic [31:0] a,
                        input logic [31:0] b, input bit fast, output int lat,
                        output logic [31:0] hi, output logic [31:0] lo, output bit stall_ok,
                        output time t_done);
    func = f; sign = s; source_a = a; source_b = b;
    lat = -1; hi = 32'hx; lo = 32'hx; t_done = 0;
    @(negedge clk);
    stall_ok = ((fast ? f_stall : stall) === 1'b1) && ((fast ? f_done : done) === 1'b0);
    step();
    func = FUNC_NONE; source_a = 32'hDEAD_BEEF; source_b = $urandom;
    for (int i = 1; i <= 80; i++) begin
      @(negedge clk);
      if ((fast ? f_done : done) === 1'b1) begin
        lat = i;
        hi = fast ? f_hi_write_data : hi_write_data;
        lo = fast ? f_lo_write_data : lo_write_data;
        t_done = $time;
        if ((fast ? f_stall : stall) !== 1'b0) stall_ok = 0;
        break;
      end
      if ((fast ? f_stall : stall) !== 1'b1) stall_ok = 0;
      step();
    end
    step();
  endtask

  task automatic test_reset;
    rst = 1; func = FUNC_MUL; sign = 0; source_a = 32'd5; source_b = 32'd6; flush = 0;
    repeat (3) step();
    @(negedge clk);
    checks++;
    if ({stall, done, hi_write, lo_write} !== 4'b0) begin
      errors++; $display("FAIL reset_strobes got %b want 0000", {stall, done, hi_write, lo_write});
    end
    checks++;
    if ({hi_write_data, lo_write_data} !== 64'd0) begin
      errors++; $display("FAIL reset_data got %h want 0", {hi_write_data, lo_write_data});
    end
    func = FUNC_NONE;
    step();
    rst = 0;
    step();
  endtask

  task automatic test_idle;
    func = 5'b00100; sign = 0; source_a = 32'd1; source_b = 32'd1;
    @(negedge clk);
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL bad_func_stall got %b want 0", stall); end
    step();
    func = FUNC_MUL; flush = 1;
    @(negedge clk);
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL flush_req_stall got %b want 0", stall); end
    step();
    func = FUNC_NONE; flush = 0;
    @(negedge clk);
    checks++;
    if ({stall, done} !== 2'b00) begin
      errors++; $display("FAIL idle_after_bad got %b want 00", {stall, done});
    end
    step();
  endtask

  task automatic test_mul;
    int lat; logic [31:0] hi, lo; bit ok; time t;
    run_op(FUNC_MUL, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, lat, hi, lo, ok, t);
    checks++;
    if (lat != 33) begin errors++; $display("FAIL multu_latency got %0d want 33", lat); end
    checks++;
    if (!ok) begin errors++; $display("FAIL multu_stall got 0 want 1 (stall N..N+32)"); end
    checks++;
    if ({hi, lo} !== 64'hFFFF_FFFE_0000_0001) begin
      errors++; $display("FAIL multu_result got %h_%h want fffffffe_00000001", hi, lo);
    end
    run_op(FUNC_MUL, 1'b1, 32'hFFFF_FFFD, 32'd7, 0, lat, hi, lo, ok, t);
    checks++;
    if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFEB) begin
      errors++; $display("FAIL mult_neg_result got %h_%h want ffffffff_ffffffeb", hi, lo);
    end
  endtask

  task automatic test_fast_mul;
    int lat; logic [31:0] hi, lo; bit ok; time t;
    run_op(FUNC_MUL, 1'b1, 32'hFFFF_FFFD, 32'd7, 1, lat, hi, lo, ok, t);
    checks++;
    if (lat != 2) begin errors++; $display("FAIL fast_latency got %0d want 2", lat); end
    checks++;
    if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFEB) begin
      errors++; $display("FAIL fast_result got %h_%h want ffffffff_ffffffeb", hi, lo);
    end
    repeat (40) step();
  endtask

  task automatic test_div;
    int lat; logic [31:0] hi, lo; bit ok; time t;
    run_op(FUNC_DIV, 1'b1, 32'hFFFF_FFF9, 32'd2, 0, lat, hi, lo, ok, t);
    checks++;
    if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFD) begin
      errors++; $display("FAIL div_neg got hi=%h lo=%h want hi=ffffffff lo=fffffffd", hi, lo);
    end
    run_op(FUNC_DIV, 1'b0, 32'd100, 32'd7, 0, lat, hi, lo, ok, t);
    checks++;
    if (lat != 33) begin errors++; $display("FAIL divu_latency got %0d want 33", lat); end
    checks++;
    if (hi !== 32'd2 || lo !== 32'd14) begin
      errors++; $display("FAIL divu_result got hi=%0d lo=%0d want hi=2 lo=14", hi, lo);
    end
    run_op(FUNC_DIV, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, lat, hi, lo, ok, t);
    checks++;
    if (hi !== 32'd0 || lo !== 32'h8000_0000) begin
      errors++; $display("FAIL div_overflow got hi=%h lo=%h want hi=0 lo=80000000", hi, lo);
    end
    run_op(FUNC_DIV, 1'b1, 32'h0000_1234, 32'd0, 0, lat, hi, lo, ok, t);
    checks++;
    if (lat != 33) begin errors++; $display("FAIL div0_latency got %0d want 33", lat); end
    checks++;
    if (hi !== 32'h0000_1234 || lo !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL div0_result got hi=%h lo=%h want hi=00001234 lo=ffffffff", hi, lo);
    end
  endtask

  task automatic test_flush;
    int lat; logic [31:0] hi, lo; bit ok; time t;
    func = FUNC_MUL; sign = 1; source_a = 32'hFFFF_FFFD; source_b = 32'd7;
    step();
    func = FUNC_NONE;
    repeat (9) step();
    flush = 1;
    @(negedge clk);
    checks++;
    if ({stall, done, hi_write, lo_write} !== 4'b0) begin
      errors++; $display("FAIL flush_mid got %b want 0000", {stall, done, hi_write, lo_write});
    end
    step();
    flush = 0;
    run_op(FUNC_DIV, 1'b0, 32'd9, 32'd4, 0, lat, hi, lo, ok, t);
    checks++;
    if (lat != 33 || hi !== 32'd1 || lo !== 32'd2) begin
      errors++; $display("FAIL after_flush got lat=%0d hi=%0d lo=%0d want lat=33 hi=1 lo=2",
                         lat, hi, lo);
    end
    func = FUNC_DIV; sign = 0; source_a = 32'd9; source_b = 32'd4;
    step();
    func = FUNC_NONE;
    repeat (32) step();
    flush = 1;
    @(negedge clk);
    checks++;
    if ({done, hi_write, lo_write} !== 3'b0) begin
      errors++; $display("FAIL flush_done got %b want 000", {done, hi_write, lo_write});
    end
    step();
    flush = 0;
    @(negedge clk);
    checks++;
    if ({stall, done} !== 2'b00) begin
      errors++; $display("FAIL flush_done_idle got %b want 00", {stall, done});
    end
    step();
  endtask

  task automatic test_reset_mid;
    int writes;
    func = FUNC_MUL; sign = 0; source_a = 32'hFFFF_FFFF; source_b = 32'hFFFF_FFFF;
    step();
    func = FUNC_NONE;
    repeat (4) step();
    rst = 1;
    step();
    rst = 0;
    @(negedge clk);
    checks++;
    if ({stall, done, hi_write, lo_write, hi_write_data, lo_write_data} !== 68'd0) begin
      errors++; $display("FAIL reset_mid_outputs got %b want 0", {stall, done, hi_write, lo_write});
    end
    writes = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      @(negedge clk);
      if (done === 1'b1 || hi_write === 1'b1 || lo_write === 1'b1) writes++;
    end
    checks++;
    if (writes != 0) begin errors++; $display("FAIL reset_mid_write got %0d want 0", writes); end
    step();
  endtask

  task automatic test_back_to_back;
    int lat1, lat2; logic [31:0] hi1, lo1, hi2, lo2; bit ok; time t1, t2;
    run_op(FUNC_MUL, 1'b0, 32'd2, 32'd3, 0, lat1, hi1, lo1, ok, t1);
    run_op(FUNC_DIV, 1'b0, 32'd9, 32'd3, 0, lat2, hi2, lo2, ok, t2);
    checks++;
    if (hi1 !== 32'd0 || lo1 !== 32'd6) begin
      errors++; $display("FAIL b2b_mul got hi=%0d lo=%0d want hi=0 lo=6", hi1, lo1);
    end
    checks++;
    if (hi2 !== 32'd0 || lo2 !== 32'd3) begin
      errors++; $display("FAIL b2b_div got hi=%0d lo=%0d want hi=0 lo=3", hi2, lo2);
    end
    checks++;
    if (lat1 < 0 || lat2 < 0 || (t2 - t1) != 340) begin
      errors++; $display("FAIL b2b_gap got %0d cycles want 34", (t2 - t1) / 10);
    end
  endtask

  initial begin
    rst = 1; flush = 0; func = FUNC_NONE; sign = 0; source_a = 0; source_b = 0;
    step();
    test_reset();
    test_idle();
    test_mul();
    test_fast_mul();
    test_div();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
